// File: rtl/ps2_transmitter_if.sv
// CPU-side handshake between the port controller and the PS/2 host transmitter.
interface ps2_transmitter_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;
  logic       rx_inhibit;

  modport master (
    output tx_data,
    output tx_start,
    input  tx_busy,
    input  tx_done,
    input  tx_error,
    input  rx_inhibit
  );

  modport slave (
    input  tx_data,
    input  tx_start,
    output tx_busy,
    output tx_done,
    output tx_error,
    output rx_inhibit
  );
endinterface

// File: rtl/ps2_transmitter.sv
// Host-to-device PS/2 transmitter: request-to-send, frame shift on device clocks, ACK check.
// Optional PS2_TX_RETRY_EN: one silent retry of the latched frame after NACK or timeout.
module ps2_transmitter #(
  parameter int unsigned INHIBIT_CYC = 6000,
  parameter int unsigned REQ_CYC     = 16,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic             clock50,
  input  logic             reset_n,
  ps2_transmitter_if.slave tx,
  input  logic             ps2_clk_in,
  input  logic             ps2_dat_in,
  output logic             ps2_clk_oe,
  output logic             ps2_dat_oe
);

  localparam int unsigned MaxIR  = (INHIBIT_CYC > REQ_CYC) ? INHIBIT_CYC : REQ_CYC;
  localparam int unsigned MaxCyc = (TIMEOUT_CYC > MaxIR) ? TIMEOUT_CYC : MaxIR;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);

  localparam logic [CntW-1:0] InhibitLast = CntW'(INHIBIT_CYC - 1);
  localparam logic [CntW-1:0] ReqLast     = CntW'(REQ_CYC - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {StIdle, StInhibit, StReq, StSend, StAck, StWaitIdle} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cyc_q, cyc_d;
  logic [3:0]      bit_q, bit_d;
  logic [9:0]      frame_q, frame_d;
  logic            err_q, err_d;
  logic            clk_oe_q, clk_oe_d;
  logic            dat_oe_q, dat_oe_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic            finish, finish_err;
`ifdef PS2_TX_RETRY_EN
  logic            retry_q, retry_d;
`endif

  // Synchronizers idle high so reset never looks like a falling edge.
  logic clk_s1_q, clk_s2_q, clk_s3_q, dat_s1_q, dat_s2_q;
  logic fall;

  always_ff @(posedge clock50 or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      clk_s3_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk_in;
      clk_s2_q <= clk_s1_q;
      clk_s3_q <= clk_s2_q;
      dat_s1_q <= ps2_dat_in;
      dat_s2_q <= dat_s1_q;
    end
  end

  assign fall = clk_s3_q & ~clk_s2_q;

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    bit_d      = bit_q;
    frame_d    = frame_q;
    err_d      = err_q;
    clk_oe_d   = clk_oe_q;
    dat_oe_d   = dat_oe_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    finish     = 1'b0;
    finish_err = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_d    = retry_q;
`endif
    unique case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        // busy_q is still high in the done cycle, so a start there is dropped.
        if (tx.tx_start && !busy_q) begin
          frame_d  = {1'b1, ~^tx.tx_data, tx.tx_data};
          state_d  = StInhibit;
          clk_oe_d = 1'b1;
          dat_oe_d = 1'b0;
          cyc_d    = '0;
          err_d    = 1'b0;
          busy_d   = 1'b1;
`ifdef PS2_TX_RETRY_EN
          retry_d  = 1'b0;
`endif
        end
      end
      StInhibit: begin
        if (cyc_q == InhibitLast) begin
          state_d  = StReq;
          dat_oe_d = 1'b1;
          cyc_d    = '0;
        end else begin
          cyc_d = cyc_q + CntW'(1);
        end
      end
      StReq: begin
        if (cyc_q == ReqLast) begin
          state_d  = StSend;
          clk_oe_d = 1'b0;
          bit_d    = 4'd0;
          cyc_d    = '0;
        end else begin
          cyc_d = cyc_q + CntW'(1);
        end
      end
      StSend: begin
        if (fall) begin
          dat_oe_d = ~frame_q[bit_q];
          bit_d    = bit_q + 4'd1;
          cyc_d    = '0;
          if (bit_q == 4'd9) state_d = StAck;
        end else if (cyc_q == TimeoutLast) begin
          finish     = 1'b1;
          finish_err = 1'b1;
        end else begin
          cyc_d = cyc_q + CntW'(1);
        end
      end
      StAck: begin
        if (fall) begin
          err_d   = dat_s2_q;
          state_d = StWaitIdle;
          cyc_d   = '0;
        end else if (cyc_q == TimeoutLast) begin
          finish     = 1'b1;
          finish_err = 1'b1;
        end else begin
          cyc_d = cyc_q + CntW'(1);
        end
      end
      StWaitIdle: begin
        if (clk_s2_q && dat_s2_q) begin
          finish     = 1'b1;
          finish_err = err_q;
        end else if (cyc_q == TimeoutLast) begin
          finish     = 1'b1;
          finish_err = 1'b1;
        end else begin
          cyc_d = cyc_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (finish) begin
      err_d = finish_err;
`ifdef PS2_TX_RETRY_EN
      if (finish_err && !retry_q) begin
        retry_d  = 1'b1;
        state_d  = StInhibit;
        clk_oe_d = 1'b1;
        dat_oe_d = 1'b0;
        cyc_d    = '0;
        err_d    = 1'b0;
      end else
`endif
      begin
        state_d  = StIdle;
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        done_d   = 1'b1;
        error_d  = finish_err;
      end
    end
  end

  always_ff @(posedge clock50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cyc_q    <= '0;
      bit_q    <= 4'd0;
      frame_q  <= 10'd0;
      err_q    <= 1'b0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      bit_q    <= bit_d;
      frame_q  <= frame_d;
      err_q    <= err_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
`ifdef PS2_TX_RETRY_EN
      retry_q  <= retry_d;
`endif
    end
  end

  assign ps2_clk_oe    = clk_oe_q;
  assign ps2_dat_oe    = dat_oe_q;
  assign tx.tx_busy    = busy_q;
  assign tx.tx_done    = done_q;
  assign tx.tx_error   = error_q;
  assign tx.rx_inhibit = busy_q;

endmodule

// File: tb/tb_ps2_transmitter.sv
// Scoreboard bench: a behavioural PS/2 device clocks frames out of the DUT and ACKs/NACKs/stalls.
module tb_ps2_transmitter;
  localparam int Inhibit = 20;
  localparam int Req     = 4;
  localparam int Timeout = 300;
  localparam int Half    = 40;

  logic clock50 = 1'b0;
  logic reset_n;
  logic ps2_clk_oe, ps2_dat_oe;
  logic dev_clk_low, dev_dat_low;
  wire  ps2_clk = ~(ps2_clk_oe | dev_clk_low);
  wire  ps2_dat = ~(ps2_dat_oe | dev_dat_low);

  ps2_transmitter_if tx_if ();

  ps2_transmitter #(
    .INHIBIT_CYC(Inhibit),
    .REQ_CYC    (Req),
    .TIMEOUT_CYC(Timeout)
  ) dut (
    .clock50   (clock50),
    .reset_n   (reset_n),
    .tx        (tx_if.slave),
    .ps2_clk_in(ps2_clk),
    .ps2_dat_in(ps2_dat),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe)
  );

  always #5 clock50 = ~clock50;

  int cyc = 0;
  always @(posedge clock50) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic [9:0] exp_frame[$];
  bit         exp_err[$];

  int dev_mode = 0;   // 0 ACK, 1 NACK, 2 stop clocking after fall 5
  bit dev_abort = 0;
  bit dev_aborted = 0;
  bit dev_active = 0;
  int dev_falls = 0;
  int frames_seen = 0;
  int last_fall_cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int done_oe = 0;

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference frame from the protocol rules: data LSB first, odd parity, stop=1.
  function automatic logic [9:0] model_frame(input int data);
    logic [9:0] f;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      f[i] = ((data >> i) % 2) == 1;
      ones += (data >> i) % 2;
    end
    f[8] = (ones % 2) == 0;
    f[9] = 1'b1;
    return f;
  endfunction

  task automatic dev_wait(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock50);
      if (dev_abort) dev_aborted = 1;
    end
  endtask

  // Device model
  initial begin
    int n;
    int got;
    logic [9:0] rx;
    logic [9:0] e;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    forever begin
      @(negedge clock50);
      if (reset_n && ps2_clk_oe && !ps2_dat_oe) begin
        dev_active  = 1;
        dev_aborted = 0;
        dev_falls   = 0;
        rx = '0;
        n = 0;
        while (ps2_clk_oe && !ps2_dat_oe && n < 1000) begin n++; @(negedge clock50); end
        check_eq("inhibit_len", n, Inhibit);
        n = 0;
        while (ps2_clk_oe && ps2_dat_oe && n < 1000) begin n++; @(negedge clock50); end
        check_eq("req_len", n, Req);
        check_eq("start_bit", {ps2_clk, ps2_dat}, 2);
        dev_wait(Half / 2);
        got = 0;
        for (int i = 0; i < 10 && !dev_aborted; i++) begin
          dev_clk_low   = 1'b1;
          dev_falls++;
          last_fall_cyc = cyc;
          dev_wait(Half);
          rx[i] = ps2_dat;
          dev_clk_low = 1'b0;
          got = i + 1;
          if (dev_mode == 2 && i == 4) break;
          dev_wait(Half);
        end
        if (got == 10 && !dev_aborted) begin
          frames_seen++;
          if (exp_frame.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame: got %h expected none", rx);
          end else begin
            e = exp_frame.pop_front();
            check_eq("frame_bits", int'(rx), int'(e));
          end
          if (dev_mode == 0) dev_dat_low = 1'b1;
          dev_wait(Half / 2);
          dev_clk_low   = 1'b1;
          last_fall_cyc = cyc;
          dev_wait(Half);
          dev_clk_low = 1'b0;
          dev_wait(10);
        end
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        dev_active  = 0;
      end
    end
  end

  // Done monitor: pops the expected error flag for every tx_done pulse.
  initial begin
    bit e;
    forever begin
      @(negedge clock50);
      if (reset_n && tx_if.tx_done) begin
        done_cnt++;
        done_cyc = cyc;
        done_oe  = {ps2_clk_oe, ps2_dat_oe};
        if (exp_err.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got tx_done=1 expected none");
        end else begin
          e = exp_err.pop_front();
          check_eq("tx_error", tx_if.tx_error, e);
        end
      end
    end
  end

  task automatic send_byte(input int data, input int mode, input bit poke);
    int nfr, d0, f0, bad, n;
    bit poked;
    dev_mode = mode;
    if (mode == 0) nfr = 1;
    else if (mode == 1) begin
`ifdef PS2_TX_RETRY_EN
      nfr = 2;
`else
      nfr = 1;
`endif
    end else nfr = 0;
    for (int i = 0; i < nfr; i++) exp_frame.push_back(model_frame(data));
    exp_err.push_back(mode != 0);
    d0 = done_cnt;
    f0 = frames_seen;
    dev_falls = 0;
    @(negedge clock50);
    tx_if.tx_data  = data[7:0];
    tx_if.tx_start = 1'b1;
    @(negedge clock50);
    bad = 0;
    poked = 0;
    n = 0;
    while (done_cnt == d0 && n < 20000) begin
      if (!(tx_if.tx_busy && tx_if.rx_inhibit)) bad++;
      tx_if.tx_start = 1'b0;
      if (poke && !poked && dev_falls >= 3) begin
        tx_if.tx_data  = ~data[7:0];
        tx_if.tx_start = 1'b1;
        poked = 1;
      end
      @(negedge clock50);
      n++;
    end
    tx_if.tx_start = 1'b0;
    check_eq("done_count", done_cnt - d0, 1);
    check_eq("busy_throughout", bad, 0);
    if (mode == 2) begin
      // Two synchronizer stages plus the edge-detect register precede the timeout count.
      check_eq("timeout_latency", done_cyc - last_fall_cyc, Timeout + 3);
      check_eq("timeout_oe", done_oe, 0);
    end
    repeat (100) @(negedge clock50);
    check_eq("frame_count", frames_seen - f0, nfr);
    check_eq("idle_after", {tx_if.tx_busy, ps2_clk_oe, ps2_dat_oe}, 0);
  endtask

  initial begin
    int d0, n, data;
    reset_n = 1'b0;
    tx_if.tx_start = 1'b0;
    tx_if.tx_data  = 8'h00;
    repeat (5) @(negedge clock50);
    check_eq("reset_state", {ps2_clk_oe, ps2_dat_oe, tx_if.tx_busy, tx_if.tx_done,
                             tx_if.tx_error, tx_if.rx_inhibit}, 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clock50);

    send_byte(8'hED, 0, 0);
    send_byte(8'hF4, 0, 0);
    send_byte(8'hFF, 1, 0);
    send_byte(8'h3C, 2, 0);
    send_byte(8'h12, 0, 1);

    // Reset in the middle of SEND
    d0 = done_cnt;
    dev_mode = 0;
    dev_falls = 0;
    @(negedge clock50);
    tx_if.tx_data  = 8'h5A;
    tx_if.tx_start = 1'b1;
    @(negedge clock50);
    tx_if.tx_start = 1'b0;
    n = 0;
    while (dev_falls < 4 && n < 5000) begin @(negedge clock50); n++; end
    check_eq("reached_send", dev_falls >= 4, 1);
    #2 reset_n = 1'b0;
    #1 check_eq("reset_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
    dev_abort = 1;
    n = 0;
    while (dev_active && n < 500) begin @(negedge clock50); n++; end
    repeat (5) @(negedge clock50);
    check_eq("no_done_on_reset", done_cnt - d0, 0);
    check_eq("busy_in_reset", tx_if.tx_busy, 0);
    reset_n = 1'b1;
    dev_abort = 0;
    repeat (5) @(negedge clock50);
    send_byte(8'hA5, 0, 0);

    for (int i = 0; i < 8; i++) begin
      data = $urandom_range(0, 255);
      send_byte(data, ($urandom_range(0, 3) == 0) ? 1 : 0, 0);
    end

    check_eq("frames_left", exp_frame.size(), 0);
    check_eq("errors_left", exp_err.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
